fp_addsub_pipe: RTL

//  Parametrised IEEE-754-style floating-point add/subtract unit; next generation of the FP ALU adder.

---
 rtl/fp_addsub_pipe.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_pipe.sv
// Parametrised floating-point add/subtract unit: one operation at a time through
// ALIGN -> ADD -> NORM -> ROUND, round-to-nearest-even, flush-to-zero, valid/ready on both sides.
module fp_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 inexact,
  output logic                 invalid
);

  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int SIG_W  = MAN_W + 4;  // hidden + fraction + G,R,S
  localparam int SUM_W  = MAN_W + 5;
  localparam int SH_MAX = MAN_W + 3;
  localparam int LZ_W   = $clog2(SIG_W + 1);

  typedef enum logic [2:0] {S_IDLE, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_HOLD} state_t;

  state_t state_q, state_d;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: next-state is defaulted first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_ALIGN;
      S_ALIGN: state_d = S_ADD;
      S_ADD:   state_d = S_NORM;
      S_NORM:  state_d = S_ROUND;
      S_ROUND: state_d = S_HOLD;
      S_HOLD:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready = (state_q == S_IDLE);

  // ---------------- operand decode (ALIGN) ----------------
  logic [W-1:0]       op_a, op_b;
  logic               op_sub;
  logic               sa, sb;
  logic [EXP_W-1:0]   ea, eb;
  logic [MAN_W-1:0]   ma, mb;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, swap;
  logic [W-2:0]       a_mag, b_mag;
  logic [SIG_W-1:0]   a_sig, b_sig, big_sig, small_sig, small_shift, lost_mask;
  logic [EXP_W-1:0]   big_exp, small_exp, diff;
  logic               big_sign;
  int                 sh_amt;
  logic               sp_hit;
  logic               sp_inv;
  logic [W-1:0]       sp_word;

  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  assign sa = op_a[W-1];
  assign sb = op_b[W-1] ^ op_sub;  // effective sign of B
  assign ea = op_a[W-2:MAN_W];
  assign eb = op_b[W-2:MAN_W];
  assign ma = op_a[MAN_W-1:0];
  assign mb = op_b[MAN_W-1:0];

  assign a_nan  = (ea == '1) && (ma != '0);
  assign b_nan  = (eb == '1) && (mb != '0);
  assign a_inf  = (ea == '1) && (ma == '0);
  assign b_inf  = (eb == '1) && (mb == '0);
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);

  assign a_mag = a_zero ? '0 : op_a[W-2:0];
  assign b_mag = b_zero ? '0 : op_b[W-2:0];
  assign a_sig = a_zero ? '0 : {1'b1, ma, 3'b000};
  assign b_sig = b_zero ? '0 : {1'b1, mb, 3'b000};
  assign swap  = (b_mag > a_mag);

  assign big_sign  = swap ? sb    : sa;
  assign big_exp   = swap ? eb    : ea;
  assign big_sig   = swap ? b_sig : a_sig;
  assign small_exp = swap ? ea    : eb;
  assign small_sig = swap ? a_sig : b_sig;
  assign diff      = big_exp - small_exp;

  // Alignment shift; every bit pushed past S is folded into S.
  always_comb begin
    sh_amt      = (int'(diff) > SH_MAX) ? SH_MAX : int'(diff);
    lost_mask   = ~({SIG_W{1'b1}} << sh_amt);
    small_shift = small_sig >> sh_amt;
    small_shift[0] = small_shift[0] | (|(small_sig & lost_mask));
  end

  always_comb begin
    sp_hit  = a_nan | b_nan | a_inf | b_inf;
    sp_inv  = 1'b0;
    sp_word = QNAN;
    if (a_nan || b_nan) begin
      sp_inv = 1'b1;
    end else if (a_inf && b_inf) begin
      if (sa != sb) sp_inv  = 1'b1;
      else          sp_word = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (a_inf) begin
      sp_word = {sa, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      sp_word = {sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // ---------------- stage registers ----------------
  logic [SIG_W-1:0] al_big, al_small;
  logic [EXP_W-1:0] al_exp;
  logic             al_sign, al_eff_sub, al_zero_sign;
  logic             sp_hit_q, sp_inv_q;
  logic [W-1:0]     sp_word_q;
  logic [SUM_W-1:0] ad_sum;
  logic [SIG_W-1:0] nm_man;
  logic [EXP_W:0]   nm_exp;
  logic             nm_zero, nm_uf;

  logic [SIG_W-1:0] norm_man;
  int               norm_exp_i;
  logic [LZ_W-1:0]  lz;

  function automatic logic [LZ_W-1:0] lzc(input logic [SIG_W-1:0] v);
    logic [LZ_W-1:0] cnt;
    cnt = LZ_W'(SIG_W);
    for (int i = 0; i < SIG_W; i++) if (v[i]) cnt = LZ_W'(SIG_W - 1 - i);
    return cnt;
  endfunction

  assign lz = lzc(ad_sum[SIG_W-1:0]);

  always_comb begin
    if (ad_sum[SUM_W-1]) begin
      norm_man    = ad_sum[SUM_W-1:1];
      norm_man[0] = ad_sum[1] | ad_sum[0];
      norm_exp_i  = int'(al_exp) + 1;
    end else begin
      norm_man    = ad_sum[SIG_W-1:0] << lz;
      norm_exp_i  = int'(al_exp) - int'(lz);
    end
  end

  // NOTE: datapath registers carry no reset; they are always written before being consumed.
  always_ff @(posedge clk) begin
    case (state_q)
      S_IDLE: if (in_valid) begin
        op_a   <= a;
        op_b   <= b;
        op_sub <= sub;
      end
      S_ALIGN: begin
        al_big       <= big_sig;
        al_small     <= small_shift;
        al_exp       <= big_exp;
        al_sign      <= big_sign;
        al_eff_sub   <= sa ^ sb;
        al_zero_sign <= sa & sb;
        sp_hit_q     <= sp_hit;
        sp_inv_q     <= sp_inv;
        sp_word_q    <= sp_word;
      end
      S_ADD: ad_sum <= al_eff_sub ? ({1'b0, al_big} - {1'b0, al_small})
                                  : ({1'b0, al_big} + {1'b0, al_small});
      S_NORM: begin
        nm_man  <= norm_man;
        nm_exp  <= norm_exp_i[EXP_W:0];
        nm_zero <= (ad_sum == '0);
        nm_uf   <= (norm_exp_i <= 0);
      end
      default: ;
    endcase
  end

  // ---------------- ROUND ----------------
  logic             g_bit, r_bit, s_bit, rnd_inc;
  logic [MAN_W+1:0] rnd_sig;
  logic [EXP_W:0]   rnd_exp;
  logic [MAN_W-1:0] rnd_frac;
  logic [W-1:0]     fin_result;
  logic [3:0]       fin_flags;  // {overflow, underflow, inexact, invalid}

  assign g_bit    = nm_man[2];
  assign r_bit    = nm_man[1];
  assign s_bit    = nm_man[0];
  assign rnd_inc  = g_bit & (r_bit | s_bit | nm_man[3]);
  assign rnd_sig  = {1'b0, nm_man[SIG_W-1:3]} + {{(MAN_W+1){1'b0}}, rnd_inc};
  assign rnd_exp  = nm_exp + {{EXP_W{1'b0}}, rnd_sig[MAN_W+1]};
  assign rnd_frac = rnd_sig[MAN_W+1] ? rnd_sig[MAN_W:1] : rnd_sig[MAN_W-1:0];

  always_comb begin
    fin_result = '0;
    fin_flags  = 4'b0000;
    if (sp_hit_q) begin
      fin_result = sp_word_q;
      fin_flags  = {3'b000, sp_inv_q};
    end else if (nm_zero) begin
      fin_result = {al_zero_sign, {(W-1){1'b0}}};
    end else if (nm_uf) begin
      fin_result = {al_sign, {(W-1){1'b0}}};
      fin_flags  = 4'b0110;
    end else if (rnd_exp >= {1'b0, {EXP_W{1'b1}}}) begin
      fin_result = {al_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      fin_flags  = 4'b1010;
    end else begin
      fin_result = {al_sign, rnd_exp[EXP_W-1:0], rnd_frac};
      fin_flags  = {2'b00, g_bit | r_bit | s_bit, 1'b0};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      inexact   <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && in_valid) begin
        {overflow, underflow, inexact, invalid} <= 4'b0000;
      end
      if (state_q == S_ROUND) begin
        out_valid <= 1'b1;
        result    <= fin_result;
        {overflow, underflow, inexact, invalid} <= fin_flags;
      end
      if (state_q == S_HOLD && out_ready) out_valid <= 1'b0;
    end
  end

endmodule
